// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives the instruction-memory
// address and captures fetched words into the IF/ID pipeline register.
module if_stage #(
  parameter int unsigned          PC_W     = 32,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_data_i,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            valid_o,
  output logic            misalign_o
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_STALL,
    ACT_REDIRECT
  } fetch_act_e;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redirect_target;
  fetch_act_e      act;

  // Wraps modulo 2^PC_W by construction; no overflow flag is wanted.
  assign pc_inc          = pc_q + PC_W'(4);
  assign redirect_target = {redirect_pc_i[PC_W-1:2], 2'b00};

  // Redirect wins over stall; reset is handled ahead of this in the register.
  always_comb begin
    act = ACT_ADVANCE;
    if (redirect_i)   act = ACT_REDIRECT;
    else if (stall_i) act = ACT_STALL;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      instr_o    <= 32'h0000_0000;
      pc_plus4_o <= '0;
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      unique case (act)
        ACT_REDIRECT: begin
          pc_q       <= redirect_target;
          instr_o    <= 32'h0000_0000;
          pc_plus4_o <= '0;
          valid_o    <= 1'b0;
          if (redirect_pc_i[1:0] != 2'b00) misalign_o <= 1'b1;
        end
        ACT_STALL: ;
        default: begin
          pc_q       <= pc_inc;
          instr_o    <= imem_data_i;
          pc_plus4_o <= pc_inc;
          valid_o    <= 1'b1;
        end
      endcase
    end
  end

  assign pc_o        = pc_q;
  assign imem_addr_o = pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a combinational imem model.
module tb_if_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        misalign_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  if_stage #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_data_i   (imem_data_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .pc_plus4_o    (pc_plus4_o),
    .valid_o       (valid_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    if (addr == 32'h0)      return 32'h2008_0005;
    else if (addr == 32'h4) return 32'h0000_0000;
    else                    return {~addr[15:0], addr[15:0]};
  endfunction

  assign imem_data_i = imem(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] pp4, input logic vld);
    check({tag, ".pc"},    pc_o,        pc);
    check({tag, ".addr"},  imem_addr_o, pc);
    check({tag, ".instr"}, instr_o,     instr);
    check({tag, ".pp4"},   pc_plus4_o,  pp4);
    check({tag, ".valid"}, {31'b0, valid_o}, {31'b0, vld});
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step(); step();
    check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
    check("reset.mis", {31'b0, misalign_o}, 32'h0);

    rst_i = 1'b0;
    step();
    check_ifid("first", 32'h4, 32'h2008_0005, 32'h4, 1'b1);
    step();
    check_ifid("second", 32'h8, 32'h0, 32'h8, 1'b1);

    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid($sformatf("stall%0d", i), 32'h8, 32'h0, 32'h8, 1'b1);
    end
    stall_i = 1'b0;
    step();
    check_ifid("stall_rel", 32'hC, imem(32'h8), 32'hC, 1'b1);

    redirect_i = 1'b1; redirect_pc_i = 32'h40; stall_i = 1'b1;
    step();
    check_ifid("redir_stall", 32'h40, 32'h0, 32'h0, 1'b0);
    check("redir_stall.mis", {31'b0, misalign_o}, 32'h0);
    redirect_i = 1'b0; stall_i = 1'b0;
    step();
    check_ifid("redir_fetch", 32'h44, imem(32'h40), 32'h44, 1'b1);

    redirect_i = 1'b1; redirect_pc_i = 32'h80;
    step();
    redirect_i = 1'b0; stall_i = 1'b1;
    step(); step();
    check_ifid("held_bubble", 32'h80, 32'h0, 32'h0, 1'b0);
    stall_i = 1'b0;
    step();
    check_ifid("bubble_rel", 32'h84, imem(32'h80), 32'h84, 1'b1);

    redirect_i = 1'b1; redirect_pc_i = 32'h43;
    step();
    check_ifid("misal", 32'h40, 32'h0, 32'h0, 1'b0);
    check("misal.mis", {31'b0, misalign_o}, 32'h1);
    redirect_pc_i = 32'h100;
    step();
    check_ifid("b2b", 32'h100, 32'h0, 32'h0, 1'b0);
    check("b2b.mis", {31'b0, misalign_o}, 32'h1);

    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    check("wrap.redir_pc", pc_o, 32'hFFFF_FFFC);
    redirect_i = 1'b0;
    step();
    check_ifid("wrap", 32'h0, imem(32'hFFFF_FFFC), 32'h0, 1'b1);
    check("wrap.mis", {31'b0, misalign_o}, 32'h1);

    for (int i = 0; i < 8; i++) step();
    check_ifid("to_20", 32'h20, imem(32'h1C), 32'h20, 1'b1);
    stall_i = 1'b1;
    step();
    rst_i = 1'b1;
    step();
    check_ifid("rst_stall", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst_stall.mis", {31'b0, misalign_o}, 32'h0);

    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    step();
    check_ifid("rst_redir", 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst_redir.mis", {31'b0, misalign_o}, 32'h0);
    rst_i = 1'b0; redirect_i = 1'b0;
    step();
    check_ifid("rerelease", 32'h4, 32'h2008_0005, 32'h4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
